tdm_demux_1ton: RTL and testbench
=================================

// Module: tdm_demux_1toN
// PURPOSE
//   Receive end of the team's time-division sample link: one WIDTH-bit sample stream
//   carries CHANNELS lanes round-robin, with in_sof marking channel 0.
//   Routes each sample to its per-channel output register and pulses that channel's strobe.
//   Tracks frame alignment (HUNT/LOCKED) and counts sync errors.
//   Sits between the link receiver and the per-lane consumers.
// PARAMETERS
//   WIDTH     8   bits per sample
//   CHANNELS  4   lanes per frame; legal range 2..16
//   SLOT_W    clog2(CHANNELS), derived localparam; not overridable
// PORTS
//   clk        in   1               rising-edge clock, single domain
//   rst_n      in   1               synchronous active-low reset
//   in_valid   in   1               in_data/in_sof qualify this cycle
//   in_data    in   WIDTH           sample
//   in_sof     in   1               sample is channel 0 of a frame; ignored when !in_valid
//   out_data   out  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
//   out_valid  out  CHANNELS        one-cycle strobe; bit k set when out_data[k] is updated
//   frame_done out  1               one-cycle pulse with the write of channel CHANNELS-1
//   locked     out  1               high in LOCKED state
//   sync_err   out  1               one-cycle pulse per detected alignment error
//   err_count  out  8               sync errors seen, saturates at 255
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): state=HUNT, slot=0, out_data=0, out_valid=0, frame_done=0,
//     locked=0, sync_err=0, err_count=0. Reset wins over every input, including mid-frame.
//   - All outputs are registered. Latency is 1 cycle: an accepted sample at edge N appears
//     on out_data and out_valid after edge N.
//   - out_data[k] holds its value until channel k is written again. out_valid and frame_done
//     are 0 in every cycle with no write.
//   - Cycles with in_valid=0 are ignored. slot and state are held; there is no timeout.
//   - HUNT:
//       valid & sof  -> write ch0, slot=1, go to LOCKED
//       valid & !sof -> sample dropped, no error, stay in HUNT
//   - LOCKED, slot==s:
//       valid & !sof & s!=0 -> write ch s; slot=s+1, wrapping CHANNELS-1 -> 0
//       valid & sof & s==0  -> write ch0, slot=1
//       valid & sof & s!=0  -> early SOF: sync_err pulse, err_count++, write ch0, slot=1,
//                              stay LOCKED (resync); no frame_done
//       valid & !sof & s==0 -> missing SOF: sync_err pulse, err_count++, sample dropped,
//                              go to HUNT
//   - frame_done is asserted in the same cycle as out_valid[CHANNELS-1].
//   - CHANNELS not a power of 2: the slot counter wraps explicitly at CHANNELS-1;
//     slot values >= CHANNELS are unreachable.
//   - err_count holds at 255 and never wraps. It is cleared only by reset.
// STRUCTURE
//   - Shared header tdm_defs.vh: state encodings ST_HUNT=1'b0, ST_LOCKED=1'b1, and the
//     ERR_CNT_W=8 constant. The TDM multiplexer (transmit end) includes the same header.
//   - Sub-module tdm_slot_counter (inputs: clk, rst_n, clr, load1, inc; output: slot)
//     owns the wrap logic. The top level holds the FSM, the output registers and the
//     error counter.
// TESTING
//   1. Reset, then a frame with sof on the first sample, data 0x11,0x22,0x33,0x44
//      -> out_valid 0001,0010,0100,1000 on consecutive cycles; frame_done with 0x44;
//      out_data=0x44332211; locked=1 after the first sample.
//   2. In HUNT: 3 samples without sof, then an aligned frame -> the first 3 are dropped,
//      sync_err never pulses, the frame is delivered as in test 1.
//   3. LOCKED with slot=2: a sample 0xAA with sof -> sync_err pulse, err_count=1,
//      out_data ch0=0xAA, no frame_done; the next 3 samples fill ch1..ch3 and frame_done
//      fires with ch3.
//   4. LOCKED with slot=0: a sample without sof -> sync_err, err_count+1, no out_valid,
//      locked=0 on the next cycle; the next sof relocks.
//   5. in_valid gaps of 1..5 cycles inside a frame -> slot is held and all strobes occur
//      only on valid cycles; 300 forced errors -> err_count=255.
//   6. Assert rst_n=0 for one cycle mid-frame (slot=2) -> all outputs 0, locked=0;
//      a non-sof sample that follows is dropped without error.
//   7. Repeat tests 1-6 with CHANNELS=3, WIDTH=16.

Source files
------------

// File: rtl/tdm_demux_1ton_pkg.sv
// ============================================================================
// tdm_demux_1ton_pkg : shared TDM link definitions (state codes, error width)
// Revision: 1.0
// ============================================================================
`default_nettype none

package tdm_demux_1ton_pkg;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } tdm_state_e;

  localparam int ERR_CNT_W = 8;

  // Slot index width; a 2-lane link still needs one bit.
  function automatic int slot_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tdm_demux_1ton_slot_counter.sv
// ============================================================================
// tdm_slot_counter : frame slot counter with explicit wrap at CHANNELS-1
// Revision: 1.0
// ============================================================================
`default_nettype none

module tdm_slot_counter
  import tdm_demux_1ton_pkg::*;
#(
  parameter  int CHANNELS = 4,
  localparam int SLOT_W   = slot_width(CHANNELS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load1,
  input  logic              inc,
  output logic [SLOT_W-1:0] slot
);

  localparam logic [SLOT_W-1:0] C_LAST = SLOT_W'(CHANNELS - 1);
  localparam logic [SLOT_W-1:0] C_ONE  = SLOT_W'(1);

  logic [SLOT_W-1:0] r_slot;

  // Wrap is explicit so non-power-of-2 lane counts never reach slot >= CHANNELS.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_slot <= '0;
    end else if (load1) begin
      r_slot <= C_ONE;
    end else if (inc) begin
      r_slot <= (r_slot == C_LAST) ? '0 : r_slot + C_ONE;
    end
  end

  assign slot = r_slot;

endmodule

`default_nettype wire

// File: rtl/tdm_demux_1ton.sv
// ============================================================================
// tdm_demux_1ton : 1-to-N TDM sample demultiplexer with frame-alignment tracking
// Revision: 1.0
// ============================================================================
`default_nettype none

module tdm_demux_1ton
  import tdm_demux_1ton_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_sof,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  output logic                      frame_done,
  output logic                      locked,
  output logic                      sync_err,
  output logic [ERR_CNT_W-1:0]      err_count
);

  localparam int SLOT_W = slot_width(CHANNELS);
  localparam logic [SLOT_W-1:0] C_LAST = SLOT_W'(CHANNELS - 1);

  tdm_state_e                r_state;
  logic [CHANNELS*WIDTH-1:0] r_out_data;
  logic [CHANNELS-1:0]       r_out_valid;
  logic                      r_frame_done;
  logic                      r_sync_err;
  logic [ERR_CNT_W-1:0]      r_err_count;

  logic [SLOT_W-1:0] w_slot;
  logic              w_wr_en;
  logic [SLOT_W-1:0] w_wr_ch;
  logic              w_err;
  logic              w_clr;
  logic              w_load1;
  logic              w_inc;

  tdm_slot_counter #(
    .CHANNELS (CHANNELS)
  ) u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .load1 (w_load1),
    .inc   (w_inc),
    .slot  (w_slot)
  );

  // Per-sample decision: which lane to write, whether alignment broke, and how the slot moves.
  always_comb begin
    w_wr_en = 1'b0;
    w_wr_ch = w_slot;
    w_err   = 1'b0;
    w_clr   = 1'b0;
    w_load1 = 1'b0;
    w_inc   = 1'b0;
    if (in_valid) begin
      if (r_state == ST_HUNT) begin
        if (in_sof) begin
          w_wr_en = 1'b1;
          w_wr_ch = '0;
          w_load1 = 1'b1;
        end
      end else if (in_sof) begin
        w_wr_en = 1'b1;
        w_wr_ch = '0;
        w_load1 = 1'b1;
        w_err   = (w_slot != '0);
      end else if (w_slot != '0) begin
        w_wr_en = 1'b1;
        w_inc   = 1'b1;
      end else begin
        w_err   = 1'b1;
        w_clr   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_HUNT;
      r_out_data   <= '0;
      r_out_valid  <= '0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      r_err_count  <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        r_out_valid[k] <= w_wr_en && (w_wr_ch == SLOT_W'(k));
        if (w_wr_en && (w_wr_ch == SLOT_W'(k))) begin
          r_out_data[k*WIDTH +: WIDTH] <= in_data;
        end
      end
      r_frame_done <= w_wr_en && (w_wr_ch == C_LAST);
      r_sync_err   <= w_err;
      if (w_err && (r_err_count != '1)) begin
        r_err_count <= r_err_count + ERR_CNT_W'(1);
      end
      // Any SOF (re)locks; an error without SOF is a missing SOF and drops to hunt.
      if (in_valid && in_sof) begin
        r_state <= ST_LOCKED;
      end else if (w_err) begin
        r_state <= ST_HUNT;
      end
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign frame_done = r_frame_done;
  assign locked     = (r_state == ST_LOCKED);
  assign sync_err   = r_sync_err;
  assign err_count  = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux_1ton.sv
// ============================================================================
// tb_tdm_demux_1ton : bench for 4x8 and 3x16 demux instances driven in parallel
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tdm_demux_1ton;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [15:0] in_data = '0;

  logic [31:0] od4;
  logic [3:0]  ov4;
  logic        fd4, lk4, se4;
  logic [7:0]  ec4;
  logic [47:0] od3;
  logic [2:0]  ov3;
  logic        fd3, lk3, se3;
  logic [7:0]  ec3;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tdm_demux_1ton #(.WIDTH(8), .CHANNELS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data[7:0]), .in_sof(in_sof),
    .out_data(od4), .out_valid(ov4), .frame_done(fd4), .locked(lk4), .sync_err(se4),
    .err_count(ec4)
  );

  tdm_demux_1ton #(.WIDTH(16), .CHANNELS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .out_data(od3), .out_valid(ov3), .frame_done(fd3), .locked(lk3), .sync_err(se3),
    .err_count(ec3)
  );

  // Reference model: frame position as a plain integer, one record per instance.
  int          m_pos [2];
  bit          m_lock[2];
  int          m_cnt [2];
  logic [15:0] m_data[2][16];
  logic [15:0] m_vm  [2];
  bit          m_fd  [2];
  bit          m_se  [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input int c, input int ch, input int w,
                            input bit r, input bit v, input bit s, input logic [15:0] d);
    logic [15:0] mask;
    int          wr;
    mask = 16'((32'd1 << w) - 1);
    wr = -1;
    m_vm[c] = '0;
    m_fd[c] = 1'b0;
    m_se[c] = 1'b0;
    if (!r) begin
      m_lock[c] = 1'b0;
      m_pos[c]  = 0;
      m_cnt[c]  = 0;
      for (int k = 0; k < 16; k++) m_data[c][k] = '0;
    end else if (v) begin
      if (s) begin
        if (m_lock[c] && m_pos[c] != 0) m_se[c] = 1'b1;
        wr = 0;
        m_pos[c]  = 1 % ch;
        m_lock[c] = 1'b1;
      end else if (m_lock[c]) begin
        if (m_pos[c] == 0) begin
          m_se[c]   = 1'b1;
          m_lock[c] = 1'b0;
        end else begin
          wr = m_pos[c];
          m_pos[c] = (m_pos[c] + 1) % ch;
        end
      end
    end
    if (wr >= 0) begin
      m_data[c][wr] = d & mask;
      m_vm[c][wr]   = 1'b1;
      m_fd[c]       = (wr == ch - 1);
    end
    if (m_se[c] && m_cnt[c] < 255) m_cnt[c]++;
  endtask

  task automatic check_dut(input int c, input string tag, input int ch, input int w,
                           input logic [255:0] od, input logic [15:0] ov, input logic fd,
                           input logic lk, input logic se, input logic [7:0] ec);
    logic [255:0] sh;
    logic [15:0]  mask;
    mask = 16'((32'd1 << w) - 1);
    chk({tag, ".out_valid"}, 32'(ov), 32'(m_vm[c]));
    chk({tag, ".frame_done"}, 32'(fd), 32'(m_fd[c]));
    chk({tag, ".locked"}, 32'(lk), 32'(m_lock[c]));
    chk({tag, ".sync_err"}, 32'(se), 32'(m_se[c]));
    chk({tag, ".err_count"}, 32'(ec), 32'(m_cnt[c]));
    for (int k = 0; k < ch; k++) begin
      sh = od >> (k * w);
      chk($sformatf("%s.data%0d", tag, k), 32'(sh[15:0] & mask), 32'(m_data[c][k]));
    end
  endtask

  task automatic drive(input bit r, input bit v, input bit s, input logic [15:0] d);
    @(negedge clk);
    rst_n = r; in_valid = v; in_sof = s; in_data = d;
    @(posedge clk);
    model_step(0, 4, 8, r, v, s, d);
    model_step(1, 3, 16, r, v, s, d);
    #1;
    check_dut(0, "c4", 4, 8, 256'(od4), 16'(ov4), fd4, lk4, se4, ec4);
    check_dut(1, "c3", 3, 16, 256'(od3), 16'(ov3), fd3, lk3, se3, ec3);
  endtask

  typedef struct {
    bit          r, v, s;
    logic [7:0]  d;
    logic [3:0]  ov;
    bit          fd, lk, se;
    logic [7:0]  cnt;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(bit r, bit v, bit s, logic [7:0] d, logic [3:0] ov,
                               bit fd, bit lk, bit se, logic [7:0] cnt, logic [31:0] data);
    vec_t t;
    t.r = r; t.v = v; t.s = s; t.d = d; t.ov = ov; t.fd = fd; t.lk = lk; t.se = se;
    t.cnt = cnt; t.data = data;
    return t;
  endfunction

  initial begin
    for (int c = 0; c < 2; c++) begin
      m_pos[c] = 0; m_lock[c] = 0; m_cnt[c] = 0; m_vm[c] = '0; m_fd[c] = 0; m_se[c] = 0;
      for (int k = 0; k < 16; k++) m_data[c][k] = '0;
    end

    // Hand-derived expectations for the 4-lane, 8-bit instance.
    tbl.push_back(mkv(0,0,0,8'h00, 4'b0000,0,0,0,8'd0, 32'h00000000));
    tbl.push_back(mkv(1,1,1,8'h11, 4'b0001,0,1,0,8'd0, 32'h00000011));
    tbl.push_back(mkv(1,1,0,8'h22, 4'b0010,0,1,0,8'd0, 32'h00002211));
    tbl.push_back(mkv(1,1,0,8'h33, 4'b0100,0,1,0,8'd0, 32'h00332211));
    tbl.push_back(mkv(1,1,0,8'h44, 4'b1000,1,1,0,8'd0, 32'h44332211));
    tbl.push_back(mkv(0,1,1,8'h77, 4'b0000,0,0,0,8'd0, 32'h00000000));
    tbl.push_back(mkv(1,1,0,8'h01, 4'b0000,0,0,0,8'd0, 32'h00000000));
    tbl.push_back(mkv(1,1,0,8'h02, 4'b0000,0,0,0,8'd0, 32'h00000000));
    tbl.push_back(mkv(1,1,0,8'h03, 4'b0000,0,0,0,8'd0, 32'h00000000));
    tbl.push_back(mkv(1,1,1,8'h11, 4'b0001,0,1,0,8'd0, 32'h00000011));
    tbl.push_back(mkv(1,1,0,8'h22, 4'b0010,0,1,0,8'd0, 32'h00002211));
    tbl.push_back(mkv(1,1,0,8'h33, 4'b0100,0,1,0,8'd0, 32'h00332211));
    tbl.push_back(mkv(1,1,0,8'h44, 4'b1000,1,1,0,8'd0, 32'h44332211));
    tbl.push_back(mkv(1,1,1,8'h55, 4'b0001,0,1,0,8'd0, 32'h44332255));
    tbl.push_back(mkv(1,1,0,8'h66, 4'b0010,0,1,0,8'd0, 32'h44336655));
    tbl.push_back(mkv(1,1,1,8'hAA, 4'b0001,0,1,1,8'd1, 32'h443366AA));
    tbl.push_back(mkv(1,1,0,8'h77, 4'b0010,0,1,0,8'd1, 32'h443377AA));
    tbl.push_back(mkv(1,1,0,8'h88, 4'b0100,0,1,0,8'd1, 32'h448877AA));
    tbl.push_back(mkv(1,1,0,8'h99, 4'b1000,1,1,0,8'd1, 32'h998877AA));
    tbl.push_back(mkv(1,1,0,8'hBB, 4'b0000,0,0,1,8'd2, 32'h998877AA));
    tbl.push_back(mkv(1,1,0,8'hCC, 4'b0000,0,0,0,8'd2, 32'h998877AA));
    tbl.push_back(mkv(1,1,1,8'hDD, 4'b0001,0,1,0,8'd2, 32'h998877DD));
    tbl.push_back(mkv(1,0,0,8'hEE, 4'b0000,0,1,0,8'd2, 32'h998877DD));

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].s, {8'h00, tbl[i].d});
      chk($sformatf("v%0d.out_valid", i), 32'(ov4), 32'(tbl[i].ov));
      chk($sformatf("v%0d.frame_done", i), 32'(fd4), 32'(tbl[i].fd));
      chk($sformatf("v%0d.locked", i), 32'(lk4), 32'(tbl[i].lk));
      chk($sformatf("v%0d.sync_err", i), 32'(se4), 32'(tbl[i].se));
      chk($sformatf("v%0d.err_count", i), 32'(ec4), 32'(tbl[i].cnt));
      chk($sformatf("v%0d.out_data", i), od4, tbl[i].data);
    end

    // Invalid gaps of 1..5 cycles between samples of aligned frames.
    drive(1, 1, 1, 16'($urandom));
    for (int g = 1; g <= 5; g++) begin
      for (int j = 0; j < g; j++) drive(1, 0, (j % 2) == 0, 16'($urandom));
      drive(1, 1, 0, 16'($urandom));
    end

    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom % 250) != 0, ($urandom % 4) != 0, ($urandom % 4) == 0, 16'($urandom));
    end

    // Saturation: back-to-back SOFs are early-SOF errors on both instances.
    drive(0, 0, 0, 16'h0);
    drive(1, 1, 1, 16'h1234);
    for (int i = 0; i < 300; i++) drive(1, 1, 1, 16'($urandom));
    chk("sat4.err_count", 32'(ec4), 32'd255);
    chk("sat3.err_count", 32'(ec3), 32'd255);
    chk("sat4.locked", 32'(lk4), 32'd1);

    // Reset mid-frame at slot 2, then a stray non-SOF sample.
    drive(1, 1, 1, 16'hA5A5);
    drive(1, 1, 0, 16'h5A5A);
    drive(0, 1, 0, 16'hFFFF);
    chk("rst4.out_data", od4, 32'h0);
    chk("rst3.out_data", 32'(od3[31:0] | od3[47:32]), 32'h0);
    chk("rst4.locked", 32'(lk4), 32'd0);
    chk("rst4.err_count", 32'(ec4), 32'd0);
    drive(1, 1, 0, 16'h1357);
    chk("post4.sync_err", 32'(se4), 32'd0);
    chk("post4.out_valid", 32'(ov4), 32'd0);
    chk("post3.locked", 32'(lk3), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
